seg_595_scan: RTL and testbench

Display driver directly downstream of the binary-to-BCD converter. Takes the four BCD digits (units, tens, hundreds, thousands), applies leading-zero blanking, decimal points and segment encoding, and time-multiplexes the digits. Each digit is serialised into the board's two cascaded 74HC595 shift registers, which drive the 6-position common-anode 7-segment display.

---
 rtl/seg_595_scan.sv | 223 ++++++++++++++++++++++
 tb/tb_seg_595_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_595_scan.sv
// -----------------------------------------------------------------------------
// seg_595_scan
//
// Purpose:
//   Scanned driver for a 6-position common-anode 7-segment display that is fed
//   through two cascaded 74HC595 shift registers. Each scan slot selects one of
//   the four BCD digits (units, tens, hundreds, thousands). The digit is given
//   leading-zero blanking, its decimal point and an active-low segment code.
//   It is then shifted out as a 14-bit frame {seg[7:0], sel[5:0]}, LSB first,
//   and latched with a single stcp pulse.
//
// Parameters:
//   CNT_SCAN_MAX  scan slot length minus one, in sys_clk cycles (>= 63 so a
//                 57-cycle frame always completes inside its slot)
//
// Ports:
//   sys_clk   in   system clock
//   sys_rst   in   asynchronous, active-high reset
//   unit      in   [3:0] BCD units digit     (display index 0)
//   ten       in   [3:0] BCD tens digit      (display index 1)
//   hun       in   [3:0] BCD hundreds digit  (display index 2)
//   tho       in   [3:0] BCD thousands digit (display index 3)
//   point     in   [3:0] decimal-point enables, point[i] lights DP of digit i
//   seg_en    in   1 = display on, 0 = all digits dark
//   ds        out  595 serial data
//   shcp      out  595 shift clock
//   stcp      out  595 storage (latch) clock
//   oe        out  595 output enable, active low
// -----------------------------------------------------------------------------
module seg_595_scan #(
  parameter int CNT_SCAN_MAX = 49_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] unit,
  input  logic [3:0] ten,
  input  logic [3:0] hun,
  input  logic [3:0] tho,
  input  logic [3:0] point,
  input  logic       seg_en,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe
);

  localparam int CNT_W = $clog2(CNT_SCAN_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } ser_state_t;

  // ---------------------------------------------------------------------------
  // Slot counter and digit index
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_scan;
  logic [1:0]       digit_idx;
  logic             scan_tick;
  logic             slot_wrap;

  // The counter sits at zero through reset, so the first cycle after release is
  // a tick; every wrap back to zero produces the following ticks.
  assign scan_tick = (cnt_scan == '0);
  assign slot_wrap = (cnt_scan == CNT_W'(CNT_SCAN_MAX));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_scan <= '0;
    end else if (slot_wrap) begin
      cnt_scan <= '0;
    end else begin
      cnt_scan <= cnt_scan + CNT_W'(1);
    end
  end

  // The index advances on the wrap edge, so the tick that follows sees the new
  // digit; 2-bit arithmetic gives the 3 -> 0 wrap with no idle slot.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      digit_idx <= 2'd0;
    end else if (slot_wrap) begin
      digit_idx <= digit_idx + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame word: digit select, blanking, DP, segment encode
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] seg_encode(input logic [3:0] val);
    logic [7:0] code;
    case (val)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hBF;  // non-BCD values show a dash
    endcase
    return code;
  endfunction

  logic [3:0]  digit_val;
  logic        digit_blank;
  logic [7:0]  seg_body;
  logic [7:0]  seg_code;
  logic [5:0]  sel_code;
  logic [13:0] frame_word;

  // NOTE: every signal driven here receives a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    digit_val   = unit;
    digit_blank = 1'b0;
    case (digit_idx)
      2'd0: begin
        digit_val   = unit;
        digit_blank = 1'b0;
      end
      2'd1: begin
        digit_val   = ten;
        digit_blank = (tho == 4'd0) && (hun == 4'd0) && (ten == 4'd0);
      end
      2'd2: begin
        digit_val   = hun;
        digit_blank = (tho == 4'd0) && (hun == 4'd0);
      end
      default: begin
        digit_val   = tho;
        digit_blank = (tho == 4'd0);
      end
    endcase

    seg_body = digit_blank ? 8'hFF : seg_encode(digit_val);
    // The DP is applied even to a blanked digit.
    seg_code = {seg_body[7] & ~point[digit_idx], seg_body[6:0]};
    sel_code = 6'b000001 << digit_idx;

    if (!seg_en) begin
      seg_code = 8'hFF;
      sel_code = 6'b000000;
    end

    frame_word = {seg_code, sel_code};
  end

  // ---------------------------------------------------------------------------
  // Serialiser: four cycles per bit, shcp rising mid-bit, one stcp cycle after
  // the 14th bit.
  // ---------------------------------------------------------------------------
  ser_state_t  state;
  ser_state_t  state_nxt;
  logic [1:0]  phase;
  logic [3:0]  bit_cnt;
  logic [13:0] shift_reg;
  logic        last_bit_end;

  assign last_bit_end = (phase == 2'd3) && (bit_cnt == 4'd13);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (scan_tick) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit_end) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The frame is captured at the tick; inputs are ignored for the rest of the
  // slot. ds always presents shift_reg[0], which moves on at the end of a bit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shift_reg <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 4'd0;
    end else if (state == S_IDLE && scan_tick) begin
      shift_reg <= frame_word;
      phase     <= 2'd0;
      bit_cnt   <= 4'd0;
    end else if (state == S_SHIFT) begin
      phase <= phase + 2'd1;
      if (phase == 2'd3) begin
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + 4'd1;
      end
    end
  end

  // Outputs decode directly from state, so an asynchronous reset drops them
  // within the same cycle and a partial frame never reaches stcp.
  always_comb begin
    ds   = (state == S_SHIFT) & shift_reg[0];
    shcp = (state == S_SHIFT) & phase[1];
    stcp = (state == S_LATCH);
  end

  // Output enable releases one cycle after reset and then stays active.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      oe <= 1'b1;
    end else begin
      oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_595_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_595_scan
//
// Self-checking bench for seg_595_scan with CNT_SCAN_MAX = 99.
// A reference model follows the slot timing from the cycle count since reset
// release. At each tick it pushes the expected frame word and tick cycle into
// a queue. A monitor rebuilds the frame from ds at each shcp rise and pops the
// queue at every stcp.
// -----------------------------------------------------------------------------
module tb_seg_595_scan;

  localparam int SCAN_MAX = 99;
  localparam int SLOT     = SCAN_MAX + 1;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] unit    = 4'd0;
  logic [3:0] ten     = 4'd0;
  logic [3:0] hun     = 4'd0;
  logic [3:0] tho     = 4'd0;
  logic [3:0] point   = 4'd0;
  logic       seg_en  = 1'b1;
  logic       ds;
  logic       shcp;
  logic       stcp;
  logic       oe;

  seg_595_scan #(.CNT_SCAN_MAX(SCAN_MAX)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .unit    (unit),
    .ten     (ten),
    .hun     (hun),
    .tho     (tho),
    .point   (point),
    .seg_en  (seg_en),
    .ds      (ds),
    .shcp    (shcp),
    .stcp    (stcp),
    .oe      (oe)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [13:0] w;
    int          tick;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;  // posedges seen since reset release

  function automatic logic [13:0] ref_word(input int idx, input logic [3:0] u,
                                           input logic [3:0] t, input logic [3:0] h,
                                           input logic [3:0] th, input logic [3:0] pt,
                                           input logic en);
    logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [3:0] d [4];
    logic [7:0] seg;
    logic [5:0] sel;
    bit         lead;
    d[0] = u; d[1] = t; d[2] = h; d[3] = th;
    // A digit is a leading zero when it and every more significant digit are 0.
    lead = (idx != 0);
    for (int j = idx; j < 4; j++) if (d[j] != 4'd0) lead = 0;
    if (lead)            seg = 8'hFF;
    else if (d[idx] < 10) seg = lut[d[idx]];
    else                 seg = 8'hBF;
    if (pt[idx]) seg[7] = 1'b0;
    sel = '0;
    sel[idx] = 1'b1;
    if (!en) return {8'hFF, 6'b000000};
    return {seg, sel};
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cyc = 0;
      q.delete();
    end else begin
      if (cyc % SLOT == 0) begin
        exp_t e;
        e.w    = ref_word((cyc / SLOT) % 4, unit, ten, hun, tho, point, seg_en);
        e.tick = cyc;
        q.push_back(e);
      end
      cyc++;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [13:0] cap;
  int          nbits  = 0;
  logic        prev_shcp = 1'b0;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      check("rst_ds",   {31'd0, ds},   32'd0);
      check("rst_shcp", {31'd0, shcp}, 32'd0);
      check("rst_stcp", {31'd0, stcp}, 32'd0);
      check("rst_oe",   {31'd0, oe},   32'd1);
      nbits     = 0;
      prev_shcp = 1'b0;
    end else begin
      check("oe", {31'd0, oe}, (cyc == 0) ? 32'd1 : 32'd0);
      if (shcp && !prev_shcp) begin
        if (nbits < 14) cap[nbits] = ds;
        nbits++;
      end
      if (stcp) begin
        if (q.size() == 0) begin
          check("unexpected_stcp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("frame_word", {18'd0, cap}, {18'd0, e.w});
          check("shcp_rises", nbits, 14);
          check("stcp_latency", cyc - e.tick, 57);
        end
        nbits = 0;
      end
      prev_shcp = shcp;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic goto_pos(input int pos);
    bit found = 0;
    for (int i = 0; i < 3 * SLOT; i++) begin
      @(negedge sys_clk);
      if (!sys_rst && (cyc % SLOT == pos)) begin
        found = 1;
        break;
      end
    end
    if (!found) check("goto_timeout", 32'd1, 32'd0);
  endtask

  task automatic apply(input logic [3:0] th, input logic [3:0] h, input logic [3:0] t,
                       input logic [3:0] u, input logic [3:0] pt, input logic en);
    goto_pos(50);
    tho = th; hun = h; ten = t; unit = u; point = pt; seg_en = en;
  endtask

  task automatic run_slots(input int n);
    repeat (n * SLOT) @(negedge sys_clk);
  endtask

  initial begin
    // Reset / start, then the digit scan pattern 1,2,3,4.
    tho = 4'd1; hun = 4'd2; ten = 4'd3; unit = 4'd4; point = 4'd0; seg_en = 1'b1;
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    run_slots(8);

    // Leading-zero blanking.
    apply(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000, 1'b1); run_slots(4);
    apply(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1); run_slots(4);
    apply(4'd1, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1); run_slots(4);

    // Decimal point on a visible tens digit, DP on a blanked digit, non-BCD.
    apply(4'd0, 4'd0, 4'd5, 4'd0, 4'b0010, 1'b1); run_slots(4);
    apply(4'd0, 4'd0, 4'd0, 4'd3, 4'b1100, 1'b1); run_slots(4);
    apply(4'd0, 4'd0, 4'd0, 4'hA, 4'b0000, 1'b1); run_slots(4);
    apply(4'hF, 4'hC, 4'd0, 4'd9, 4'b1111, 1'b1); run_slots(4);

    // Disable, then re-enable.
    apply(4'd8, 4'd8, 4'd8, 4'd8, 4'b1111, 1'b0); run_slots(4);
    apply(4'd8, 4'd8, 4'd8, 4'd8, 4'b1111, 1'b1); run_slots(4);

    // Randomised inputs, one slot each.
    for (int i = 0; i < 24; i++) begin
      apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0));
      run_slots(1);
    end

    // Reset in the middle of bit 7 (shcp high), then recover at index 0.
    apply(4'd6, 4'd5, 4'd0, 4'd7, 4'b0001, 1'b1);
    goto_pos(31);
    check("mid_frame_shcp_high", {31'd0, shcp}, 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check("abort_ds",   {31'd0, ds},   32'd0);
    check("abort_shcp", {31'd0, shcp}, 32'd0);
    check("abort_stcp", {31'd0, stcp}, 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    run_slots(4);

    goto_pos(70);
    check("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
